// File: rtl/stitch_axi_wr_arbiter_pkg.sv
// Shared types and AXI constants for the stitching write arbiter.
// Holds the burst FSM state encoding and the AXI burst/response codes.
package stitch_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // AxSIZE encoding: log2 of the bytes carried per beat.
  function automatic int clog2_bytes(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/stitch_axi_wr_arbiter_if.sv
// AXI4 write-channel bundle (AW, W, B) between the arbiter and the memory side.
// The master modport is the arbiter; the slave modport is the interconnect.
interface stitch_axi_wr_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]     M_AXI_AWID;
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic [7:0]              M_AXI_AWLEN;
  logic [2:0]              M_AXI_AWSIZE;
  logic [1:0]              M_AXI_AWBURST;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WLAST;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;

  modport master (
    output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
endinterface

// File: rtl/stitch_axi_wr_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after 'last', wrapping.
// The previous winner is searched last, so no channel wins twice while others wait.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] grant,
  output logic          any_req
);

  logic [LW-1:0] idx;
  logic          found;

  always_comb begin
    grant = last;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = LW'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/stitch_axi_wr_arbiter.sv
// N-channel AXI4 write arbiter: grants ingest FIFOs round-robin and issues one
// INCR burst per grant (AW, then W, then B; never overlapped).
module stitch_axi_wr_arbiter
  import stitch_axi_pkg::*;
#(
  parameter int CH_NUM             = 5,
  parameter int C_M_AXI_BURST_LEN  = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_ID_WIDTH   = 1
) (
  input  logic                                 M_AXI_ACLK,
  input  logic                                 M_AXI_ARESETN,
  input  logic [CH_NUM-1:0]                    ch_req,
  input  logic [CH_NUM*C_M_AXI_ADDR_WIDTH-1:0] ch_addr,
  input  logic [CH_NUM*C_M_AXI_DATA_WIDTH-1:0] ch_rd_data,
  output logic [CH_NUM-1:0]                    ch_rd_en,
  output logic [CH_NUM-1:0]                    ch_done,
  output logic [CH_NUM-1:0]                    ch_err,
  stitch_axi_wr_arbiter_if.master              m_axi
);

  localparam int LW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int BCW = (C_M_AXI_BURST_LEN > 1) ? $clog2(C_M_AXI_BURST_LEN) : 1;
  localparam int AWD = C_M_AXI_ADDR_WIDTH;
  localparam int DW  = C_M_AXI_DATA_WIDTH;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(C_M_AXI_BURST_LEN - 1);

  logic [AWD-1:0] addr_arr [CH_NUM];
  logic [DW-1:0]  data_arr [CH_NUM];

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    assign addr_arr[gi] = ch_addr[gi*AWD +: AWD];
    assign data_arr[gi] = ch_rd_data[gi*DW +: DW];
  end

  state_e         state_q, state_d;
  logic [LW-1:0]  grant_q, grant_d;
  logic [LW-1:0]  last_q, last_d;
  logic [AWD-1:0] awaddr_q, awaddr_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [CH_NUM-1:0] done_q, done_d;
  logic [CH_NUM-1:0] err_q, err_d;

  logic [LW-1:0]     arb_grant;
  logic              any_req;
  logic [CH_NUM-1:0] grant_onehot;
  logic              awvalid, wvalid, wlast, bready;

  rr_arbiter #(.N(CH_NUM), .LW(LW)) u_rr (
    .req     (ch_req),
    .last    (last_q),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  assign grant_onehot = CH_NUM'(1) << grant_q;
  assign wlast        = (state_q == W) && (beat_cnt_q == LAST_BEAT);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    awaddr_d   = awaddr_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = '0;
    err_d      = '0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = AW;
          grant_d  = arb_grant;
          last_d   = arb_grant;
          awaddr_d = addr_arr[arb_grant];
        end
      end
      AW: begin
        awvalid = 1'b1;
        if (m_axi.M_AXI_AWREADY) state_d = W;
      end
      W: begin
        wvalid = 1'b1;
        if (m_axi.M_AXI_WREADY) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (wlast) begin
            beat_cnt_d = '0;
            state_d    = B;
          end
        end
      end
      B: begin
        bready = 1'b1;
        if (m_axi.M_AXI_BVALID) begin
          state_d = IDLE;
          if (m_axi.M_AXI_BRESP == RESP_OKAY) done_d = grant_onehot;
          else                                err_d  = grant_onehot;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to the top channel so that channel 0 wins the first search.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= LW'(CH_NUM - 1);
      awaddr_q   <= '0;
      beat_cnt_q <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      awaddr_q   <= awaddr_d;
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Popping only on the W handshake keeps the FWFT head (and so WDATA) frozen while stalled.
  assign ch_rd_en = (wvalid && m_axi.M_AXI_WREADY) ? grant_onehot : '0;
  assign ch_done  = done_q;
  assign ch_err   = err_q;

  assign m_axi.M_AXI_AWID    = '0;
  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign m_axi.M_AXI_AWSIZE  = 3'(clog2_bytes(DW));
  assign m_axi.M_AXI_AWBURST = BURST_INCR;
  assign m_axi.M_AXI_AWVALID = awvalid;
  assign m_axi.M_AXI_WDATA   = data_arr[grant_q];
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WLAST   = wlast;
  assign m_axi.M_AXI_WVALID  = wvalid;
  assign m_axi.M_AXI_BREADY  = bready;

endmodule

// File: doc/stitch_axi_wr_arbiter.md
# stitch_axi_wr_arbiter

Parametrised N-channel AXI4 write arbiter for the video-stitching datapath. Each camera-ingest channel buffers pixels in its own first-word-fall-through (FWFT) FIFO and raises a request once a full burst is ready. The arbiter grants channels round-robin, issues one INCR write burst per grant on the shared AXI-FULL master write channels, and reports completion or error back to the granted channel. It replaces per-design hard-wired write muxing and scales from 1 to 16 channels.

## Interface
- CH_NUM, 5, number of ingest channels (1..16)
- C_M_AXI_BURST_LEN, 32, beats per burst (1..256)
- C_M_AXI_DATA_WIDTH, 128, AXI data width (32/64/128/256)
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_ID_WIDTH, 1, AXI ID width
- M_AXI_ACLK  in  1  sole clock; all logic rising-edge
- M_AXI_ARESETN  in  1  asynchronous active-low reset
- ch_req  in  CH_NUM  channel i holds ≥ C_M_AXI_BURST_LEN beats in its FIFO
- ch_addr  in  CH_NUM*ADDR_WIDTH  burst start address for channel i; slice i = [i*AW +: AW]
- ch_rd_data  in  CH_NUM*DATA_WIDTH  FWFT FIFO head of channel i
- ch_rd_en  out  CH_NUM  pops one beat from channel i
- ch_done  out  CH_NUM  1-cycle pulse when channel i's burst gets BRESP=OKAY
- ch_err  out  CH_NUM  1-cycle pulse when channel i's burst gets BRESP≠OKAY
- M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out; M_AXI_AWREADY  in
- M_AXI_WDATA/WSTRB/WLAST/WVALID  out; M_AXI_WREADY  in
- M_AXI_BRESP  in  2; M_AXI_BVALID  in; M_AXI_BREADY  out

## Operation
- FSM states:
  - IDLE → AW when any ch_req is set. In that same cycle, register grant = next set request after last_grant (cyclic search), register AWADDR from ch_addr[grant], and update last_grant.
  - AW: AWVALID=1 until the AWREADY handshake, then → W.
  - W: WVALID=1, WDATA=ch_rd_data[grant] (combinational), ch_rd_en[grant]=WVALID&WREADY, beat_cnt increments per handshake. WLAST=(beat_cnt==BURST_LEN-1). Handshake with WLAST → B.
  - B: BREADY=1. On BVALID, pulse ch_done[grant] (if BRESP==2'b00) or ch_err[grant], then → IDLE.
- Constant outputs:
  - AWID=0
  - AWLEN=BURST_LEN-1
  - AWSIZE=clog2(DATA_WIDTH/8)
  - AWBURST=2'b01 (INCR)
  - WSTRB all ones
- AW and W are not overlapped; only one burst is outstanding.
- ch_req is sampled only in IDLE. A request that drops after grant is ignored and the burst completes.
- ch_addr must be aligned to BURST_LEN*DATA_WIDTH/8. The block never splits bursts at 4 KB boundaries.
- last_grant resets to CH_NUM-1, so channel 0 wins the first arbitration.
- CH_NUM=1 degenerates to an always-grant-0 path.

## Timing
- Reset values:
  - AWVALID, WVALID, WLAST, BREADY = 0
  - ch_rd_en, ch_done, ch_err = 0
  - AWADDR = 0
  - FSM = IDLE, beat_cnt = 0
- Grant latency: AWVALID rises the cycle after ch_req is seen in IDLE.
- With AWREADY/WREADY/BVALID all returned immediately: AW takes 1 cycle, W takes BURST_LEN cycles, B takes 1 cycle. Minimum period per burst is BURST_LEN+3 cycles, idle gap included.
- AXI stability: AWVALID/AWADDR stay stable while AWVALID && !AWREADY. WVALID/WDATA/WLAST stay stable while WVALID && !WREADY, because ch_rd_en is low, so the FIFO head does not move.
- ch_done/ch_err fire in the cycle after the B handshake. In that cycle the FSM is back in IDLE and may grant again.
- Asynchronous reset mid-burst: all outputs clear immediately. The partial burst is abandoned and no ch_done is issued. Clearing the channel FIFOs is the system's responsibility.

## Structure
- Shared package stitch_axi_pkg holds:
  - FSM state enum (IDLE, AW, W, B)
  - AXI constants BURST_INCR=2'b01, RESP_OKAY=2'b00
  - function clog2_bytes()
- Sub-module rr_arbiter #(N): inputs req[N], last[clog2 N]; outputs grant index and any_req. Purely combinational cyclic priority; last_grant is registered in the parent.

## Test plan
- Reset, then ch_req=5'b00001, ch_addr[0]=0x1000, ready signals held 1 → one AW to 0x1000 with AWLEN=31, AWSIZE=4; 32 W beats with WLAST on beat 32; ch_done[0] pulses once; 32 ch_rd_en[0] pulses.
- ch_req=5'b11111 held for 10 bursts → grant order 0,1,2,3,4,0,1,2,3,4; no channel is granted twice in a row.
- WREADY toggles randomly 50% during a burst → WDATA/WLAST stay stable while stalled; exactly 32 pops; data order matches the FIFO order.
- AWREADY held low for 20 cycles → AWVALID/AWADDR stay constant; no W activity before the AW handshake.
- BRESP=2'b10 on channel 2's burst → ch_err[2] pulses and ch_done[2] does not; the next grant goes to channel 3.
- ARESETN asserted at beat 15 of a burst → AWVALID/WVALID/BREADY drop to 0 immediately; no ch_done; after release, channel 0 is granted first.
